// File: rtl/sync_debounce_edge_pkg.sv
// Shared definitions for the debounce/edge-detect slice.
//   clog2_min1 : counter width helper, never returns 0 so a single-state
//                counter still has a legal 1-bit register.
package sync_debounce_edge_pkg;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sync_debounce_edge_debounce_bit.sv
// debounce_bit: single-bit debounce cell with registered edge pulses.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_data         : synchronized input bit
//   o_level        : accepted (debounced) level
//   o_rise/o_fall  : registered one-cycle acceptance pulses
//   o_rise_nxt/o_fall_nxt : next-state pulse values, so the parent can register
//                           an aggregate aligned with o_rise/o_fall
module debounce_bit
  import sync_debounce_edge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        INIT_LEVEL      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_data,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);

  localparam int unsigned   CW    = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_rise, r_fall;
  logic          w_diff, w_accept;
  logic [CW-1:0] w_cnt_nxt;

  assign w_diff   = i_data ^ r_level;
  // Acceptance happens on the DEBOUNCE_CYCLES-th consecutive differing
  // sample; the counter is cleared there, so it can never wrap.
  assign w_accept = w_diff && (r_cnt == C_MAX);

  always_comb begin
    w_cnt_nxt = '0;
    if (w_diff && !w_accept) w_cnt_nxt = r_cnt + 1'b1;
  end

  assign o_rise_nxt = w_accept &  i_data;
  assign o_fall_nxt = w_accept & ~i_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= INIT_LEVEL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      if (w_accept) r_level <= i_data;
      r_cnt  <= w_cnt_nxt;
      r_rise <= o_rise_nxt;
      r_fall <= o_fall_nxt;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge: per-bit debounce filter with rise/fall pulses, placed
// after a synchronizer.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_data         : DATA_WIDTH vector already synchronous to i_clk
//   o_level        : debounced levels
//   o_rise/o_fall  : one-cycle pulses on accepted 0->1 / 1->0 changes
//   o_any_change   : registered OR of all pulses, aligned with them
module sync_debounce_edge
  import sync_debounce_edge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        INIT_LEVEL      = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_level,
  output logic [DATA_WIDTH-1:0] o_rise,
  output logic [DATA_WIDTH-1:0] o_fall,
  output logic                  o_any_change
);

  logic [DATA_WIDTH-1:0] w_rise_nxt, w_fall_nxt;
  logic                  r_any;

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INIT_LEVEL      (INIT_LEVEL)
    ) u_bit (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_data     (i_data[k]),
      .o_level    (o_level[k]),
      .o_rise     (o_rise[k]),
      .o_fall     (o_fall[k]),
      .o_rise_nxt (w_rise_nxt[k]),
      .o_fall_nxt (w_fall_nxt[k])
    );
  end

  // Reduce the next-state pulses so the flag lands in the same cycle as them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_any <= 1'b0;
    else          r_any <= |(w_rise_nxt | w_fall_nxt);
  end

  assign o_any_change = r_any;

endmodule

// File: tb/tb_sync_debounce_edge.sv
module tb_sync_debounce_edge;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] din, din1;
  logic [7:0] lvl, rise, fall, lvl1, rise1, fall1;
  logic       any, any1;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 i_clk = ~i_clk;

  sync_debounce_edge #(.DATA_WIDTH(8), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(din),
    .o_level(lvl), .o_rise(rise), .o_fall(fall), .o_any_change(any));

  sync_debounce_edge #(.DATA_WIDTH(8), .DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b0)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(din1),
    .o_level(lvl1), .o_rise(rise1), .o_fall(fall1), .o_any_change(any1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [7:0] l, input logic [7:0] r,
                      input logic [7:0] f, input logic a);
    chk({tag, ".level"}, {24'd0, lvl},  {24'd0, l});
    chk({tag, ".rise"},  {24'd0, rise}, {24'd0, r});
    chk({tag, ".fall"},  {24'd0, fall}, {24'd0, f});
    chk({tag, ".any"},   {31'd0, any},  {31'd0, a});
  endtask

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset with all inputs high: outputs held at INIT_LEVEL regardless of clock.
    i_rst_n = 1'b0;
    din     = 8'hFF;
    din1    = 8'h00;
    #2;
    chk4("rst_pre_clk", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); step();
    chk4("rst_clocked", 8'h00, 8'h00, 8'h00, 1'b0);

    // Clean rise: first differing sample is edge 1, acceptance at edge 4.
    din     = 8'h01;
    i_rst_n = 1'b1;
    step(); chk4("rise_e1", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); chk4("rise_e2", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); chk4("rise_e3", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); chk4("rise_e4", 8'h01, 8'h01, 8'h00, 1'b1);
    step(); chk4("rise_e5", 8'h01, 8'h00, 8'h00, 1'b0);

    // Glitch reject: bit 2 high for 3 samples, then low, five times.
    for (int g = 0; g < 5; g++) begin
      din = 8'h05;
      for (int s = 0; s < 3; s++) begin
        step(); chk4("glitch_hi", 8'h01, 8'h00, 8'h00, 1'b0);
      end
      din = 8'h01;
      step(); chk4("glitch_lo", 8'h01, 8'h00, 8'h00, 1'b0);
    end

    // Move to 0F, then step everything to F0 simultaneously.
    din = 8'h0F;
    step(); step(); step();
    chk4("to0F_e3", 8'h01, 8'h00, 8'h00, 1'b0);
    step(); chk4("to0F_e4", 8'h0F, 8'h0E, 8'h00, 1'b1);
    step(); chk4("to0F_e5", 8'h0F, 8'h00, 8'h00, 1'b0);

    din = 8'hF0;
    step(); step(); step();
    chk4("simul_e3", 8'h0F, 8'h00, 8'h00, 1'b0);
    step(); chk4("simul_e4", 8'hF0, 8'hF0, 8'h0F, 1'b1);
    step(); chk4("simul_e5", 8'hF0, 8'h00, 8'h00, 1'b0);

    // Reset mid-count: 80 held for two edges, reset between edges.
    din = 8'h80;
    step(); step();
    chk4("mid_pre", 8'hF0, 8'h00, 8'h00, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk4("mid_rst_async", 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    chk4("mid_rst_held", 8'h00, 8'h00, 8'h00, 1'b0);
    i_rst_n = 1'b1;
    step(); chk4("mid_rel_e1", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); chk4("mid_rel_e2", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); chk4("mid_rel_e3", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); chk4("mid_rel_e4", 8'h80, 8'h80, 8'h00, 1'b1);
    step(); chk4("mid_rel_e5", 8'h80, 8'h00, 8'h00, 1'b0);

    // DEBOUNCE_CYCLES = 1 instance: toggle every cycle, level follows one
    // edge later and rise/fall alternate.
    chk("dc1_idle.level", {24'd0, lvl1}, 32'h0);
    for (int t = 0; t < 6; t++) begin
      din1 = (t % 2 == 0) ? 8'h01 : 8'h00;
      step();
      chk("dc1.level", {24'd0, lvl1},  {24'd0, din1});
      chk("dc1.rise",  {24'd0, rise1}, {24'd0, din1});
      chk("dc1.fall",  {24'd0, fall1}, {24'd0, ~din1 & 8'h01});
      chk("dc1.any",   {31'd0, any1},  32'h1);
    end
    step();
    chk("dc1_hold.rise", {24'd0, rise1}, 32'h0);
    chk("dc1_hold.fall", {24'd0, fall1}, 32'h0);
    chk("dc1_hold.any",  {31'd0, any1},  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Consumer stage placed directly after the n-stage synchronizer output.
- Takes a DATA_WIDTH vector that is already synchronous to i_clk.
- Per bit, filters glitches and bounce by requiring DEBOUNCE_CYCLES consecutive identical samples before accepting a new level.
- Emits the filtered level plus single-cycle rise and fall pulses for downstream control logic (button/switch inputs, slow status lines).

Parameters:
- DATA_WIDTH, 8, number of independent bits filtered in parallel.
- DEBOUNCE_CYCLES, 4, consecutive differing samples required to accept a new level. Legal range 1..65535.
- INIT_LEVEL, 1'b0, value loaded into every o_level bit on reset.

Ports:
- i_clk  input  1  clock. All logic is rising-edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data  input  DATA_WIDTH  synchronized input vector.
- o_level  output  DATA_WIDTH  debounced stable level.
- o_rise  output  DATA_WIDTH  one-cycle pulse when o_level bit goes 0->1.
- o_fall  output  DATA_WIDTH  one-cycle pulse when o_level bit goes 1->0.
- o_any_change  output  1  OR of all o_rise and o_fall bits, registered in the same cycle as the pulses.

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low (i_rst_n).
  - On reset assertion, immediately: o_level = {DATA_WIDTH{INIT_LEVEL}}; o_rise = 0; o_fall = 0; o_any_change = 0; all counters = 0.
  - Deassertion is synchronous to i_clk by the integrator. There is no internal reset synchronizer.
- Per-bit state: level register L and counter C, width CW = max(1, clog2(DEBOUNCE_CYCLES)).
- Each rising edge, for bit k:
  - If i_data[k] == L: C <= 0; no pulse.
  - If i_data[k] != L and C < DEBOUNCE_CYCLES-1: C <= C+1; no pulse.
  - If i_data[k] != L and C == DEBOUNCE_CYCLES-1:
    - L <= i_data[k]; C <= 0.
    - o_rise[k] <= i_data[k]; o_fall[k] <= ~i_data[k].
- Pulses are registered, high for exactly one cycle, and cleared on the next edge unless a new acceptance occurs. A new acceptance cannot happen on the next edge when DEBOUNCE_CYCLES > 1.
- Latency: the input changes before edge t0 and is held. o_level updates at edge t0+DEBOUNCE_CYCLES-1, i.e. on the DEBOUNCE_CYCLESth consecutive differing sample.
  - DEBOUNCE_CYCLES = 1 degenerates to a one-register delay with edge detect.
- Glitch rule: any sample equal to L clears C. A differing run shorter than DEBOUNCE_CYCLES produces no output change and no pulse.
- Bits are fully independent. Simultaneous acceptances on several bits assert the corresponding pulse bits in the same cycle, and o_any_change is asserted once.
- Counter never wraps: it saturates by construction, since acceptance resets it at DEBOUNCE_CYCLES-1.
- Reset mid-count: counters are discarded and o_level returns to INIT_LEVEL. An input still differing after release starts a fresh count from 0.
- o_any_change is registered: it is the OR of the next-state pulse bits, so it aligns with o_rise/o_fall.
- No combinational path from i_data to any output.

Decomposition:
- Shared package holds a width helper function (clog2 with minimum of 1) used for CW and by other counters in the codebase.
- One natural sub-module: debounce_bit, a single-bit cell with L, C, rise and fall.
  - Parameters: DEBOUNCE_CYCLES, INIT_LEVEL.
  - Instantiated DATA_WIDTH times in a generate loop.
- The top level adds the o_any_change reduction register.

Test Plan:
- Reset: drive i_data = 8'hFF with i_rst_n low, INIT_LEVEL = 0 -> o_level = 8'h00 and all pulses 0 while in reset, independent of the clock.
- Clean rise: after reset, i_data = 8'h01 held. With DEBOUNCE_CYCLES = 4, the first differing sample is edge 1 -> o_level = 8'h01 and o_rise = 8'h01 at edge 4 only; o_any_change = 1 for that one cycle; o_rise = 0 at edge 5.
- Glitch reject: i_data bit 2 high for 3 cycles then low, repeated 5 times (DEBOUNCE_CYCLES = 4) -> o_level[2] stays 0; no rise/fall pulse; o_any_change never asserted.
- Simultaneous bits: o_level = 8'h0F, i_data steps to 8'hF0 and is held -> after 4 edges o_level = 8'hF0, o_rise = 8'hF0, o_fall = 8'h0F in the same single cycle; o_any_change = 1 once.
- Reset mid-count: i_data = 8'h80 held for 2 edges, assert i_rst_n low asynchronously between edges, release with i_data still 8'h80 -> o_level = 8'h00 immediately on reset; o_level[7] rises exactly 4 edges after release.
- DEBOUNCE_CYCLES = 1: i_data toggles 8'h00/8'h01 every cycle -> o_level follows with one-cycle delay; o_rise and o_fall alternate each cycle.
